// File: rtl/psk_bit_slicer_pkg.sv
// Shared definitions for the PSK slicer and its neighbouring dispatcher stage:
// status-word field positions, phase geometry, FSM encoding and the
// differential-phase decision helper.
package psk_bit_slicer_pkg;

  localparam int PHASE_W   = 5;   // 32 phase steps per turn
  localparam int HALF_TURN = 16;
  localparam int LOCK_BIT  = 7;
  localparam int PHASE_MSB = 4;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_TRACK  = 1'b1
  } state_e;

  typedef struct packed {
    logic bit_val;   // decided DPSK bit
    logic erasure;   // step too far from 0 or a half turn to trust
  } decision_t;

  // A step near a half turn is a 1, near zero is a 0; the bit is simply
  // delta[4]^delta[3] so 8..23 decide 1 even when flagged as erasures.
  function automatic decision_t decide(input logic [PHASE_W-1:0] delta, input int tol);
    decision_t r;
    int        d;
    d         = int'(delta);
    r.bit_val = delta[PHASE_W-1] ^ delta[PHASE_W-2];
    r.erasure = !((d <= tol) || (d >= 2 * HALF_TURN - tol) ||
                  ((d >= HALF_TURN - tol) && (d <= HALF_TURN + tol)));
    return r;
  endfunction

endpackage

// File: rtl/psk_bit_slicer_if.sv
// Stream bundle between the correlator/dispatcher, the slicer and the
// UART/host sink. Statistics signals exist only with PSK_SLICER_STATS_EN.
interface psk_bit_slicer_if;

  logic [7:0]  in_value;
  logic        in_stb;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        locked;
  logic        ovf;
`ifdef PSK_SLICER_STATS_EN
  logic [15:0] erasure_cnt;
  logic [7:0]  unlock_cnt;
`endif

  // Driver side: feeds status words and accepts bytes.
  modport master (
    output in_value, in_stb, out_ready,
`ifdef PSK_SLICER_STATS_EN
    input  erasure_cnt, unlock_cnt,
`endif
    input  out_data, out_valid, locked, ovf
  );

  // Slicer side.
  modport slave (
    input  in_value, in_stb, out_ready,
`ifdef PSK_SLICER_STATS_EN
    output erasure_cnt, unlock_cnt,
`endif
    output out_data, out_valid, locked, ovf
  );

endinterface

// File: rtl/psk_byte_fifo.sv
// Synchronous first-word-fall-through FIFO. Push on full is refused unless a
// pop happens in the same cycle; pop on empty is ignored.
module psk_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int           AW      = $clog2(DEPTH);
  localparam logic [AW:0]  PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk or posedge rst_in) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst_in) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

  // Storage write.
  always_ff @(posedge clk or posedge rst_in) begin
    // NOTE: this tiny array is reset so the head byte reads 0 out of reset;
    // larger memories would be left unreset and mapped to RAM.
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/psk_bit_slicer.sv
// DPSK bit slicer: qualifies carrier lock, decides one bit per strobe from
// the phase step, packs bits LSB-first into bytes and queues them for the
// sink. Optional statistics outputs are enabled by PSK_SLICER_STATS_EN.
module psk_bit_slicer
  import psk_bit_slicer_pkg::*;
#(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4,
  parameter int FLIP_TOL   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              rst_in,
  psk_bit_slicer_if.slave  bus
);

  localparam logic [7:0] RUN_LAST  = 8'(LOCK_CNT - 1);
  localparam logic [7:0] MISS_LAST = 8'(UNLOCK_CNT - 1);

  state_e             state_q, state_d;
  logic [7:0]         run_q, run_d;
  logic [7:0]         miss_q, miss_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         sreg_q, sreg_d;
  logic [PHASE_W-1:0] phase_prev_q, phase_prev_d;
  logic               ovf_q;

  logic               stb, lock, track_stb, acquire, drop_lock, decode, push;
  logic [PHASE_W-1:0] phase, delta;
  logic [7:0]         byte_d;
  decision_t          dec;
  logic               fifo_full, fifo_empty;
  logic               unused_fields;

  assign stb           = bus.in_stb;
  assign lock          = bus.in_value[LOCK_BIT];
  assign phase         = bus.in_value[PHASE_MSB:0];
  assign unused_fields = ^bus.in_value[6:5];

  assign delta     = phase - phase_prev_q;
  assign dec       = decide(delta, FLIP_TOL);
  assign track_stb = stb && (state_q == ST_TRACK);
  assign acquire   = stb && (state_q == ST_SEARCH) && lock && (run_q == RUN_LAST);
  assign drop_lock = track_stb && !lock && (miss_q == MISS_LAST);
  assign decode    = track_stb && !drop_lock;
  assign byte_d    = {dec.bit_val, sreg_q[7:1]};
  assign push      = decode && (bit_cnt_q == 3'd7);

  // FSM state register.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) state_q <= ST_SEARCH;
    else        state_q <= state_d;
  end

  // FSM next state: lock run enters TRACK, miss run returns to SEARCH.
  always_comb begin
    // NOTE: default first so no path through this block infers a latch.
    state_d = state_q;
    case (state_q)
      ST_SEARCH: if (acquire)   state_d = ST_TRACK;
      ST_TRACK:  if (drop_lock) state_d = ST_SEARCH;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.locked = (state_q == ST_TRACK);
  end

  // Counter and shift-register next state; only strobes advance anything.
  always_comb begin
    run_d        = run_q;
    miss_d       = miss_q;
    bit_cnt_d    = bit_cnt_q;
    sreg_d       = sreg_q;
    phase_prev_d = phase_prev_q;
    if (stb) begin
      phase_prev_d = phase;
      if (state_q == ST_SEARCH) begin
        run_d     = (lock && !acquire) ? run_q + 8'd1 : 8'd0;
        miss_d    = 8'd0;
        bit_cnt_d = 3'd0;
        sreg_d    = 8'd0;
      end else if (drop_lock) begin
        // Losing lock throws away the partial byte.
        run_d     = 8'd0;
        miss_d    = 8'd0;
        bit_cnt_d = 3'd0;
        sreg_d    = 8'd0;
      end else begin
        miss_d    = lock ? 8'd0 : miss_q + 8'd1;
        sreg_d    = byte_d;
        bit_cnt_d = bit_cnt_q + 3'd1;   // 7 wraps to 0 as the byte is pushed
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      run_q        <= '0;
      miss_q       <= '0;
      bit_cnt_q    <= '0;
      sreg_q       <= '0;
      phase_prev_q <= '0;
    end else begin
      run_q        <= run_d;
      miss_q       <= miss_d;
      bit_cnt_q    <= bit_cnt_d;
      sreg_q       <= sreg_d;
      phase_prev_q <= phase_prev_d;
    end
  end

  // Sticky overflow: a push refused because the FIFO is full and not popping.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in)                                    ovf_q <= 1'b0;
    else if (push && fifo_full && !bus.out_ready)  ovf_q <= 1'b1;
  end

  assign bus.ovf       = ovf_q;
  assign bus.out_valid = !fifo_empty;

  psk_byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_in  (rst_in),
    .push_i  (push),
    .data_i  (byte_d),
    .pop_i   (bus.out_ready),
    .data_o  (bus.out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef PSK_SLICER_STATS_EN
  logic [15:0] erasure_cnt_q;
  logic [7:0]  unlock_cnt_q;

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      erasure_cnt_q <= '0;
      unlock_cnt_q  <= '0;
    end else begin
      if (track_stb && dec.erasure && (erasure_cnt_q != '1))
        erasure_cnt_q <= erasure_cnt_q + 16'd1;
      if (drop_lock && (unlock_cnt_q != '1))
        unlock_cnt_q <= unlock_cnt_q + 8'd1;
    end
  end

  assign bus.erasure_cnt = erasure_cnt_q;
  assign bus.unlock_cnt  = unlock_cnt_q;
`endif

endmodule

// File: tb/tb_psk_bit_slicer.sv
module tb_psk_bit_slicer;

  logic       clk = 1'b0;
  logic       rst_in;
  logic [4:0] cur_phase;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  psk_bit_slicer_if bus ();

  psk_bit_slicer #(
    .LOCK_CNT   (8),
    .UNLOCK_CNT (4),
    .FLIP_TOL   (3),
    .FIFO_DEPTH (4)
  ) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .bus    (bus)
  );

  // One strobe, driven at a falling edge; returns at the next falling edge.
  task automatic send_stb(input logic lock, input logic [4:0] ph);
    bus.in_value = {lock, 2'b00, ph};
    bus.in_stb   = 1'b1;
    cur_phase    = ph;
    @(negedge clk);
    bus.in_stb   = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    send_stb(1'b1, cur_phase + (b ? 5'd16 : 5'd0));
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic acquire_lock();
    repeat (8) send_stb(1'b1, cur_phase);
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_in        = 1'b1;
    bus.in_value  = 8'h00;
    bus.in_stb    = 1'b0;
    bus.out_ready = 1'b0;
    cur_phase     = 5'd0;
    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    @(negedge clk);
    total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", bus.locked); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.ovf); end
    total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", bus.out_data); end
  endtask

  task automatic test_acquire();
    repeat (7) send_stb(1'b1, 5'd0);
    send_stb(1'b0, 5'd0);
    total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL acq_broken_run got=%b want=0", bus.locked); end
    repeat (7) send_stb(1'b1, 5'd0);
    total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL acq_seven got=%b want=0", bus.locked); end
    send_stb(1'b1, 5'd0);
    total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL acq_eight got=%b want=1", bus.locked); end
  endtask

  task automatic test_decode();
    logic [4:0] ph [8] = '{5'd16, 5'd16, 5'd0, 5'd16, 5'd16, 5'd0, 5'd16, 5'd16};
    for (int i = 0; i < 7; i++) send_stb(1'b1, ph[i]);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL dec_early_valid got=%b want=0", bus.out_valid); end
    send_stb(1'b1, ph[7]);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL dec_valid got=%b want=1", bus.out_valid); end
    total++; if (bus.out_data !== 8'h6D) begin bad++; $display("FAIL dec_data got=%h want=6d", bus.out_data); end
    pop_one();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL dec_popped got=%b want=0", bus.out_valid); end
  endtask

  // From prev 16: steps 14,16(30->14),17,2(31->1),0,31,6(erasure),0 -> bits 1,1,1,0,0,0,0,0.
  task automatic test_wrap();
    logic [4:0] ph [8] = '{5'd30, 5'd14, 5'd31, 5'd1, 5'd1, 5'd0, 5'd6, 5'd6};
    for (int i = 0; i < 8; i++) send_stb(1'b1, ph[i]);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b want=1", bus.out_valid); end
    total++; if (bus.out_data !== 8'h07) begin bad++; $display("FAIL wrap_data got=%h want=07", bus.out_data); end
`ifdef PSK_SLICER_STATS_EN
    total++; if (bus.erasure_cnt !== 16'd1) begin bad++; $display("FAIL wrap_erasures got=%0d want=1", bus.erasure_cnt); end
`endif
    pop_one();
  endtask

  task automatic test_unlock();
    send_stb(1'b1, 5'd22);
    send_stb(1'b1, 5'd22);
    send_stb(1'b1, 5'd6);
    repeat (3) send_stb(1'b0, 5'd6);
    total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL unl_three_miss got=%b want=1", bus.locked); end
    send_stb(1'b0, 5'd6);
    total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL unl_locked got=%b want=0", bus.locked); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL unl_no_push got=%b want=0", bus.out_valid); end
`ifdef PSK_SLICER_STATS_EN
    total++; if (bus.unlock_cnt !== 8'd1) begin bad++; $display("FAIL unl_count got=%0d want=1", bus.unlock_cnt); end
`endif
    acquire_lock();
    total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL unl_relock got=%b want=1", bus.locked); end
    send_byte(8'hA5);
    total++; if (bus.out_data !== 8'hA5 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL unl_fresh_byte got=%h/%b want=a5/1", bus.out_data, bus.out_valid);
    end
    pop_one();
  endtask

  task automatic test_overflow();
    for (int b = 1; b <= 4; b++) send_byte(8'(b));
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL ovf_four got=%b want=0", bus.ovf); end
    send_byte(8'h05);
    total++; if (bus.ovf !== 1'b1) begin bad++; $display("FAIL ovf_five got=%b want=1", bus.ovf); end
    for (int b = 1; b <= 4; b++) begin
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(b)) begin
        bad++; $display("FAIL ovf_drain%0d got=%h/%b want=%h/1", b, bus.out_data, bus.out_valid, 8'(b));
      end
      pop_one();
    end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b want=0", bus.out_valid); end
    // Refill, then push the fifth byte while the head is popped on the same edge.
    for (int b = 8'h11; b <= 8'h14; b++) send_byte(8'(b));
    for (int i = 0; i < 7; i++) send_bit(1'b1 & (8'h15 >> i));
    total++; if (bus.out_data !== 8'h11) begin bad++; $display("FAIL ovf_head got=%h want=11", bus.out_data); end
    bus.out_ready = 1'b1;
    send_bit(1'b0);
    bus.out_ready = 1'b0;
    for (int b = 8'h12; b <= 8'h15; b++) begin
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(b)) begin
        bad++; $display("FAIL ovf_full_pop %h got=%h/%b", 8'(b), bus.out_data, bus.out_valid);
      end
      pop_one();
    end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ovf_final_empty got=%b want=0", bus.out_valid); end
    total++; if (bus.ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", bus.ovf); end
  endtask

  // Strobe held high for eight consecutive cycles.
  task automatic test_back_to_back();
    logic [7:0] b = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      cur_phase    = cur_phase + (b[i] ? 5'd16 : 5'd0);
      bus.in_value = {1'b1, 2'b11, cur_phase};   // ignored bits set on purpose
      bus.in_stb   = 1'b1;
      @(negedge clk);
    end
    bus.in_stb = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C) begin
      bad++; $display("FAIL b2b_byte got=%h/%b want=3c/1", bus.out_data, bus.out_valid);
    end
    pop_one();
  endtask

  task automatic test_reset_mid();
    send_byte(8'h77);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_in = 1'b1;
    #1;
    total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL mid_locked got=%b want=0", bus.locked); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL mid_ovf got=%b want=0", bus.ovf); end
`ifdef PSK_SLICER_STATS_EN
    total++; if (bus.erasure_cnt !== 16'd0 || bus.unlock_cnt !== 8'd0) begin
      bad++; $display("FAIL mid_stats got=%0d/%0d want=0/0", bus.erasure_cnt, bus.unlock_cnt);
    end
`endif
    @(negedge clk);
    rst_in    = 1'b0;
    cur_phase = 5'd0;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale got=%b want=0", bus.out_valid); end
    acquire_lock();
    send_byte(8'h5A);
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A) begin
      bad++; $display("FAIL mid_new_byte got=%h/%b want=5a/1", bus.out_data, bus.out_valid);
    end
    pop_one();
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_decode();
    test_wrap();
    test_unlock();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
